// File: rtl/seq_divider_16.sv
// seq_divider_16
//   Multi-cycle restoring divider for the MULT/DIV unit. One trial subtraction
//   and one shift per cycle. Signed (DIV) or unsigned (DIVU) operation with
//   MIPS result semantics: the quotient truncates toward zero and the
//   remainder takes the sign of the dividend.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     start        request, sampled only while idle
//     is_signed    1 = two's-complement operands, 0 = unsigned
//     dividend     numerator, sampled with start
//     divisor      denominator, sampled with start
//     busy         high while an operation is in flight
//     done         one-cycle pulse; results valid from this cycle
//     quotient     registered result, held until the next done
//     remainder    registered result, held until the next done
//     div_by_zero  registered flag, updated with done
//     overflow     registered flag (signed most-negative / -1), updated with done
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   CALC  | one shift / trial subtraction per cycle, WIDTH iterations
//   FIX   | apply result signs, load outputs, pulse done

module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] a_orig;
    logic             q_neg;
    logic             r_neg;
    logic             b_zero;
    logic             ovf_pend;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        a_neg = is_signed & dividend[WIDTH-1];
        b_neg = is_signed & divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag = b_neg ? (~divisor + 1'b1) : divisor;

        // rem < dmag is invariant, so WIDTH+1 bits hold the trial result and
        // its top bit is a clean borrow indicator.
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dmag};

        q_fix = q_neg ? (~quo + 1'b1) : quo;
        r_fix = r_neg ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dmag        <= '0;
            a_orig      <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            b_zero      <= 1'b0;
            ovf_pend    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem      <= '0;
                        quo      <= a_mag;
                        dmag     <= b_mag;
                        a_orig   <= dividend;
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        b_zero   <= (divisor == '0);
                        ovf_pend <= is_signed && (dividend == MOST_NEG) && (divisor == '1);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (diff[WIDTH]) begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    // Divide by zero overrides the datapath result so the
                    // outputs do not depend on how the iterations degenerate.
                    if (b_zero) begin
                        quotient    <= '1;
                        remainder   <= a_orig;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= 1'b0;
                        overflow    <= ovf_pend;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_16.sv
module tb_seq_divider_16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    seq_divider_16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          issue;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cycle    = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares each done against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done && busy) check("done_busy_overlap", 1, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, "_q"},   quotient,    e.q);
                    check({e.tag, "_r"},   remainder,   e.r);
                    check({e.tag, "_dz"},  div_by_zero, e.dz);
                    check({e.tag, "_ov"},  overflow,    e.ov);
                    check({e.tag, "_lat"}, cycle - e.issue, 17);
                    check({e.tag, "_busy"}, busy, 0);
                end
            end
        end
    end

    // Called at a negedge: start is sampled at the next posedge, edge N = cycle+1.
    task automatic issue(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz, input logic eov);
        exp_t e;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.issue = cycle + 1; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_hi"}, busy, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_q"},    quotient, 0);
        check({tag, "_r"},    remainder, 0);
        check({tag, "_flags"}, {div_by_zero, overflow}, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        issue("u100_7",   1'b0, 16'd100,  16'd7,   16'h000E, 16'h0002, 1'b0, 1'b0); wait_drain();
        issue("sm7_2",    1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0); wait_drain();
        issue("s7_m2",    1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0); wait_drain();
        issue("sm100_m7", 1'b1, 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0); wait_drain();
        issue("u_dz",     1'b0, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 1'b0); wait_drain();
        issue("s_dz",     1'b1, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 1'b0); wait_drain();
        issue("s_ovf",    1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1); wait_drain();
        issue("u_8000",   1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0); wait_drain();

        // Start held high with different operands while busy must be ignored,
        // then a start in the done cycle is accepted back-to-back.
        issue("u1000_7", 1'b0, 16'd1000, 16'd7, 16'h008E, 16'h0006, 1'b0, 1'b0);
        start = 1'b1;
        dividend = 16'h1234;
        divisor  = 16'h0001;
        is_signed = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", done, 1);
        issue("b2b_ffff_10", 1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 1'b0);
        wait_drain();

        // Reset 5 cycles into an operation: immediate clear, no done afterwards.
        is_signed = 1'b0;
        dividend  = 16'd1000;
        divisor   = 16'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_cleared("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("midrst_idle", busy, 0);

        issue("u9_3", 1'b0, 16'd9, 16'd3, 16'h0003, 16'h0000, 1'b0, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
